// File: rtl/judge_ctrl_if.sv
// ============================================================================
//  Interface : judge_ctrl_if
//  Purpose   : Groups the scroller-side flags, raw buttons and the
//              score/judge/tone results of judge_ctrl into one bundle.
//              slave  = judge_ctrl side, master = driver/consumer side.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

interface judge_ctrl_if;
  logic        i_tick;
  logic        i_btn_t1;
  logic        i_btn_t2;
  logic        i_hit_t1;
  logic        i_hit_t2;
  logic        i_pre_hit_t1;
  logic        i_pre_hit_t2;
  logic        i_miss_t1;
  logic        i_miss_t2;
  logic [31:0] i_curr_pitch_t1;
  logic [31:0] i_curr_pitch_t2;
  logic        o_clear_t1_perf;
  logic        o_clear_t1_norm;
  logic        o_clear_t2_perf;
  logic        o_clear_t2_norm;
  logic [15:0] o_score;
  logic [9:0]  o_combo;
  logic [9:0]  o_max_combo;
  logic [1:0]  o_judge;
  logic        o_judge_trk;
  logic        o_judge_valid;
  logic        o_tone_en;
  logic [31:0] o_tone_pitch;

  modport slave (
    input  i_tick, i_btn_t1, i_btn_t2, i_hit_t1, i_hit_t2,
           i_pre_hit_t1, i_pre_hit_t2, i_miss_t1, i_miss_t2,
           i_curr_pitch_t1, i_curr_pitch_t2,
    output o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm,
           o_score, o_combo, o_max_combo, o_judge, o_judge_trk, o_judge_valid,
           o_tone_en, o_tone_pitch
  );

  modport master (
    output i_tick, i_btn_t1, i_btn_t2, i_hit_t1, i_hit_t2,
           i_pre_hit_t1, i_pre_hit_t2, i_miss_t1, i_miss_t2,
           i_curr_pitch_t1, i_curr_pitch_t2,
    input  o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm,
           o_score, o_combo, o_max_combo, o_judge, o_judge_trk, o_judge_valid,
           o_tone_en, o_tone_pitch
  );
endinterface

`default_nettype wire

// File: rtl/judge_ctrl.sv
// ============================================================================
//  Module    : judge_ctrl
//  Purpose   : Hit-judgement stage behind the LCD note scroller. Debounces
//              the two track buttons, grades presses against the slot flags
//              (slot 0 = PERFECT, slot 1 = NORMAL), pulses clears back to the
//              scroller and keeps score / combo / max combo.
//  Option    : JUDGE_TONE_EN - builds the feedback tone latch and timer;
//              when undefined the tone outputs are tied to 0.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module judge_ctrl #(
  parameter int DEBOUNCE_MS = 3,
  parameter int LOCK_MS     = 40,
  parameter int PERF_PTS    = 10,
  parameter int NORM_PTS    = 5,
  parameter int TONE_MS     = 120
) (
  input wire          clk,
  input wire          rst,
  judge_ctrl_if.slave bus
);

  localparam int c_DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam int c_LK_W = $clog2(LOCK_MS + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_MS - 1);
  localparam logic [c_LK_W-1:0] c_LK_LAST = c_LK_W'(LOCK_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_JUDGE = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  logic [1:0] w_btn;
  logic [1:0] w_hit;
  logic [1:0] w_pre;
  logic [1:0] w_perf;
  logic [1:0] w_norm;

  assign w_btn = {bus.i_btn_t2, bus.i_btn_t1};
  assign w_hit = {bus.i_hit_t2, bus.i_hit_t1};
  assign w_pre = {bus.i_pre_hit_t2, bus.i_pre_hit_t1};

  genvar t;
  for (t = 0; t < 2; t++) begin : g_trk
    logic [1:0]        r_sync;
    logic              r_stable;
    logic              r_armed;
    logic              r_press;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [c_LK_W-1:0] r_lock_cnt;
    state_t            r_state;
    logic              w_rise;

    // Accepted 0->1 change; r_armed blocks a button that was held through reset.
    assign w_rise = bus.i_tick & r_sync[1] & ~r_stable & r_armed & (r_db_cnt == c_DB_LAST);

    // Synchronise, then debounce on ticks: stable level flips after N equal samples.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync   <= '0;
        r_stable <= 1'b0;
        r_armed  <= 1'b0;
        r_press  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_sync  <= {r_sync[0], w_btn[t]};
        r_press <= w_rise;
        if (bus.i_tick) begin
          if (r_sync[1] == r_stable) begin
            r_db_cnt <= '0;
            if (!r_stable) r_armed <= 1'b1;
          end else if (r_db_cnt == c_DB_LAST) begin
            r_db_cnt <= '0;
            r_stable <= r_sync[1];
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
      end
    end

    // Per-track IDLE -> JUDGE (1 clk) -> LOCK (LOCK_MS ticks) sequencer.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= S_IDLE;
        r_lock_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE:  if (r_press) r_state <= S_JUDGE;
          S_JUDGE: begin
            r_state    <= S_LOCK;
            r_lock_cnt <= '0;
          end
          S_LOCK: begin
            if (bus.i_tick) begin
              if (r_lock_cnt == c_LK_LAST) r_state <= S_IDLE;
              else                         r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    // Grade against the flags present during JUDGE; clears exist only then.
    assign w_perf[t] = (r_state == S_JUDGE) & w_hit[t];
    assign w_norm[t] = (r_state == S_JUDGE) & ~w_hit[t] & w_pre[t];
  end

  assign bus.o_clear_t1_perf = w_perf[0];
  assign bus.o_clear_t1_norm = w_norm[0];
  assign bus.o_clear_t2_perf = w_perf[1];
  assign bus.o_clear_t2_norm = w_norm[1];

  logic [15:0] r_score;
  logic [9:0]  r_combo;
  logic [9:0]  r_max_combo;
  logic [1:0]  r_judge;
  logic        r_judge_trk;
  logic        r_judge_valid;

  logic [15:0] w_pts0;
  logic [15:0] w_pts1;
  logic [16:0] w_score_sum;
  logic [15:0] w_score_nx;
  logic [1:0]  w_hits;
  logic [10:0] w_combo_sum;
  logic [9:0]  w_combo_nx;
  logic        w_any_miss;
  logic        w_valid;
  logic [1:0]  w_judge;
  logic        w_trk;

  // Combine both tracks: saturating score/combo and prioritised report.
  always_comb begin
    w_pts0 = '0;
    w_pts1 = '0;
    if (w_perf[0])      w_pts0 = 16'(PERF_PTS);
    else if (w_norm[0]) w_pts0 = 16'(NORM_PTS);
    if (w_perf[1])      w_pts1 = 16'(PERF_PTS);
    else if (w_norm[1]) w_pts1 = 16'(NORM_PTS);
    w_score_sum = {1'b0, r_score} + {1'b0, w_pts0} + {1'b0, w_pts1};
    w_score_nx  = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

    w_hits      = {1'b0, w_perf[0] | w_norm[0]} + {1'b0, w_perf[1] | w_norm[1]};
    w_combo_sum = {1'b0, r_combo} + {9'd0, w_hits};
    w_any_miss  = bus.i_miss_t1 | bus.i_miss_t2;
    if (w_any_miss)                 w_combo_nx = {8'd0, w_hits};
    else if (w_combo_sum > 11'd1023) w_combo_nx = 10'd1023;
    else                            w_combo_nx = w_combo_sum[9:0];

    w_valid = w_any_miss | (|w_perf) | (|w_norm);
    w_judge = 2'd0;
    w_trk   = 1'b0;
    if (bus.i_miss_t1)      begin w_judge = 2'd3; w_trk = 1'b0; end
    else if (bus.i_miss_t2) begin w_judge = 2'd3; w_trk = 1'b1; end
    else if (w_perf[0])     begin w_judge = 2'd1; w_trk = 1'b0; end
    else if (w_perf[1])     begin w_judge = 2'd1; w_trk = 1'b1; end
    else if (w_norm[0])     begin w_judge = 2'd2; w_trk = 1'b0; end
    else if (w_norm[1])     begin w_judge = 2'd2; w_trk = 1'b1; end
  end

  // Register score, combo and the judgement report.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score       <= '0;
      r_combo       <= '0;
      r_max_combo   <= '0;
      r_judge       <= '0;
      r_judge_trk   <= 1'b0;
      r_judge_valid <= 1'b0;
    end else begin
      r_score       <= w_score_nx;
      r_combo       <= w_combo_nx;
      r_judge_valid <= w_valid;
      if (w_combo_nx > r_max_combo) r_max_combo <= w_combo_nx;
      if (w_valid) begin
        r_judge     <= w_judge;
        r_judge_trk <= w_trk;
      end
    end
  end

  assign bus.o_score       = r_score;
  assign bus.o_combo       = r_combo;
  assign bus.o_max_combo   = r_max_combo;
  assign bus.o_judge       = r_judge;
  assign bus.o_judge_trk   = r_judge_trk;
  assign bus.o_judge_valid = r_judge_valid;

`ifdef JUDGE_TONE_EN
  localparam int c_TN_W = $clog2(TONE_MS + 1);
  localparam logic [c_TN_W-1:0] c_TN_LAST = c_TN_W'(TONE_MS - 1);

  logic              r_tone_en;
  logic [31:0]       r_tone_pitch;
  logic [c_TN_W-1:0] r_tone_cnt;
  logic              w_tone_hit;
  logic [31:0]       w_tone_src;

  // Pick the pitch of the highest-priority graded track.
  always_comb begin
    w_tone_hit = (|w_perf) | (|w_norm);
    if (w_perf[0])      w_tone_src = bus.i_curr_pitch_t1;
    else if (w_perf[1]) w_tone_src = bus.i_curr_pitch_t2;
    else if (w_norm[0]) w_tone_src = bus.i_curr_pitch_t1;
    else                w_tone_src = bus.i_curr_pitch_t2;
  end

  // Tone timer: a hit (re)starts it, a miss kills it immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tone_en    <= 1'b0;
      r_tone_pitch <= '0;
      r_tone_cnt   <= '0;
    end else if (w_any_miss) begin
      r_tone_en <= 1'b0;
    end else if (w_tone_hit) begin
      r_tone_en    <= 1'b1;
      r_tone_pitch <= w_tone_src;
      r_tone_cnt   <= '0;
    end else if (r_tone_en && bus.i_tick) begin
      if (r_tone_cnt == c_TN_LAST) r_tone_en  <= 1'b0;
      else                         r_tone_cnt <= r_tone_cnt + 1'b1;
    end
  end

  assign bus.o_tone_en    = r_tone_en;
  assign bus.o_tone_pitch = r_tone_pitch;
`else
  logic w_unused_pitch;
  assign w_unused_pitch   = ^{bus.i_curr_pitch_t1, bus.i_curr_pitch_t2};
  assign bus.o_tone_en    = 1'b0;
  assign bus.o_tone_pitch = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_judge_ctrl.sv
// ============================================================================
//  Module    : tb_judge_ctrl
//  Purpose   : Directed self-checking bench for judge_ctrl. A second instance
//              with 1-tick debounce/lock reaches score/combo saturation fast.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_judge_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  judge_ctrl_if bus ();
  judge_ctrl_if sbus ();

  judge_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  judge_ctrl #(
    .DEBOUNCE_MS (1),
    .LOCK_MS     (1)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters for the main instance, sampled mid-cycle.
  int n_t1p = 0, n_t1n = 0, n_t2p = 0, n_t2n = 0, n_val = 0;
  int b_t1p, b_t1n, b_t2p, b_t2n, b_val;

  always @(negedge clk) begin
    if (bus.o_clear_t1_perf) n_t1p++;
    if (bus.o_clear_t1_norm) n_t1n++;
    if (bus.o_clear_t2_perf) n_t2p++;
    if (bus.o_clear_t2_norm) n_t2n++;
    if (bus.o_judge_valid)   n_val++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick period: 3 quiet clocks then a 1-clk tick strobe.
  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) step();
      bus.i_tick = 1'b1;
      step();
      bus.i_tick = 1'b0;
    end
  endtask

  task automatic mark();
    b_t1p = n_t1p; b_t1n = n_t1n; b_t2p = n_t2p; b_t2n = n_t2n; b_val = n_val;
  endtask

  task automatic sat_round(input logic both);
    sbus.i_btn_t1 = 1'b1;
    sbus.i_btn_t2 = both;
    repeat (4) step();
    sbus.i_btn_t1 = 1'b0;
    sbus.i_btn_t2 = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    bus.i_tick = 0; bus.i_btn_t1 = 0; bus.i_btn_t2 = 0;
    bus.i_hit_t1 = 0; bus.i_hit_t2 = 0; bus.i_pre_hit_t1 = 0; bus.i_pre_hit_t2 = 0;
    bus.i_miss_t1 = 0; bus.i_miss_t2 = 0;
    bus.i_curr_pitch_t1 = 0; bus.i_curr_pitch_t2 = 0;
    sbus.i_tick = 1; sbus.i_btn_t1 = 0; sbus.i_btn_t2 = 0;
    sbus.i_hit_t1 = 1; sbus.i_hit_t2 = 1; sbus.i_pre_hit_t1 = 0; sbus.i_pre_hit_t2 = 0;
    sbus.i_miss_t1 = 0; sbus.i_miss_t2 = 0;
    sbus.i_curr_pitch_t1 = 0; sbus.i_curr_pitch_t2 = 0;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_score", bus.o_score, 0);
    check("rst_combo", bus.o_combo, 0);
    check("rst_max", bus.o_max_combo, 0);
    check("rst_judge", bus.o_judge, 0);
    check("rst_valid", bus.o_judge_valid, 0);
    check("rst_tone", bus.o_tone_en, 0);
    check("rst_clear", {bus.o_clear_t1_perf, bus.o_clear_t1_norm,
                        bus.o_clear_t2_perf, bus.o_clear_t2_norm}, 0);
    tk(2);

    // PERFECT on track 1
    mark();
    bus.i_hit_t1 = 1; bus.i_curr_pitch_t1 = 440;
    bus.i_btn_t1 = 1; tk(5); bus.i_btn_t1 = 0; tk(45);
    bus.i_hit_t1 = 0;
    check("t1_perf_pulse", n_t1p - b_t1p, 1);
    check("t1_norm_pulse", n_t1n - b_t1n, 0);
    check("t1_score", bus.o_score, 10);
    check("t1_combo", bus.o_combo, 1);
    check("t1_judge", bus.o_judge, 1);
    check("t1_trk", bus.o_judge_trk, 0);
    check("t1_valid_cnt", n_val - b_val, 1);

    // NORMAL on track 2
    mark();
    bus.i_pre_hit_t2 = 1;
    bus.i_btn_t2 = 1; tk(5); bus.i_btn_t2 = 0; tk(45);
    check("t2_norm_pulse", n_t2n - b_t2n, 1);
    check("t2_perf_pulse", n_t2p - b_t2p, 0);
    check("t2_score", bus.o_score, 15);
    check("t2_combo", bus.o_combo, 2);
    check("t2_judge", bus.o_judge, 2);
    check("t2_trk", bus.o_judge_trk, 1);

    // Empty press on track 2
    mark();
    bus.i_pre_hit_t2 = 0;
    bus.i_btn_t2 = 1; tk(5); bus.i_btn_t2 = 0; tk(45);
    check("empty_pulses", (n_t2n - b_t2n) + (n_t2p - b_t2p), 0);
    check("empty_valid", n_val - b_val, 0);
    check("empty_score", bus.o_score, 15);
    check("empty_combo", bus.o_combo, 2);

    // Bounce 1-0-1-0 gives nothing
    mark();
    bus.i_hit_t1 = 1;
    bus.i_btn_t1 = 1; tk(1); bus.i_btn_t1 = 0; tk(1);
    bus.i_btn_t1 = 1; tk(1); bus.i_btn_t1 = 0; tk(4);
    check("bounce_pulse", n_t1p - b_t1p, 0);

    // Clean hold gives one press; re-press inside LOCK is dropped
    mark();
    bus.i_btn_t1 = 1; tk(3); bus.i_btn_t1 = 0; tk(5);
    bus.i_btn_t1 = 1; tk(4); bus.i_btn_t1 = 0; tk(45);
    check("lock_pulse", n_t1p - b_t1p, 1);
    check("lock_score", bus.o_score, 25);
    check("lock_combo", bus.o_combo, 3);

    // Simultaneous PERFECTs on both tracks
    mark();
    bus.i_hit_t2 = 1;
    bus.i_btn_t1 = 1; bus.i_btn_t2 = 1; tk(4);
    bus.i_btn_t1 = 0; bus.i_btn_t2 = 0; tk(45);
    check("dual_t1p", n_t1p - b_t1p, 1);
    check("dual_t2p", n_t2p - b_t2p, 1);
    check("dual_score", bus.o_score, 45);
    check("dual_combo", bus.o_combo, 5);
    check("dual_valid_cnt", n_val - b_val, 1);
    check("dual_judge", bus.o_judge, 1);
    check("dual_trk", bus.o_judge_trk, 0);
    bus.i_btn_t1 = 1; bus.i_btn_t2 = 1; tk(4);
    bus.i_btn_t1 = 0; bus.i_btn_t2 = 0; tk(45);
    check("dual2_combo", bus.o_combo, 7);
    check("dual2_max", bus.o_max_combo, 7);

    // Miss on t1 in the same clk as a t2 PERFECT grade
    mark();
    bus.i_hit_t1 = 0;
    bus.i_btn_t2 = 1; tk(3);
    step();
    bus.i_miss_t1 = 1;
    step();
    bus.i_miss_t1 = 0;
    check("miss_combo", bus.o_combo, 1);
    check("miss_max", bus.o_max_combo, 7);
    check("miss_judge", bus.o_judge, 3);
    check("miss_trk", bus.o_judge_trk, 0);
    check("miss_valid", bus.o_judge_valid, 1);
    check("miss_score", bus.o_score, 75);
    step();
    check("miss_valid_1clk", bus.o_judge_valid, 0);
    check("miss_t2p", n_t2p - b_t2p, 1);
    bus.i_btn_t2 = 0; bus.i_hit_t2 = 0; tk(45);

    // Feedback tone
    bus.i_hit_t1 = 1; bus.i_curr_pitch_t1 = 523;
    bus.i_btn_t1 = 1; tk(3); step(); step();
    bus.i_btn_t1 = 0;
    check("tone_score", bus.o_score, 85);
`ifdef JUDGE_TONE_EN
    check("tone_en_on", bus.o_tone_en, 1);
    check("tone_pitch", bus.o_tone_pitch, 523);
    tk(119);
    check("tone_en_119", bus.o_tone_en, 1);
    tk(1);
    check("tone_en_120", bus.o_tone_en, 0);
`else
    check("tone_off", bus.o_tone_en, 0);
    check("tone_pitch0", bus.o_tone_pitch, 0);
    tk(45);
    check("tone_off_late", bus.o_tone_en, 0);
`endif

    // Reset during LOCK with the button held through it
    bus.i_btn_t1 = 1; tk(3); step(); step();
    check("pre_rst_score", bus.o_score, 95);
    tk(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_score", bus.o_score, 0);
    check("mid_rst_combo", bus.o_combo, 0);
    check("mid_rst_max", bus.o_max_combo, 0);
    check("mid_rst_judge", {bus.o_judge, bus.o_judge_trk, bus.o_judge_valid}, 0);
    check("mid_rst_tone", {bus.o_tone_en, bus.o_tone_pitch != 32'd0}, 0);
    mark();
    tk(10);
    check("held_no_press", n_t1p - b_t1p, 0);
    bus.i_btn_t1 = 0; tk(4);
    bus.i_btn_t1 = 1; tk(4); bus.i_btn_t1 = 0;
    repeat (3) step();
    check("repress_pulse", n_t1p - b_t1p, 1);
    check("repress_score", bus.o_score, 10);

    // Saturation on the fast instance
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int r = 0; r < 3276; r++) sat_round(1'b1);
    check("sat_score_65520", sbus.o_score, 65520);
    check("sat_combo", sbus.o_combo, 1023);
    check("sat_max", sbus.o_max_combo, 1023);
    sat_round(1'b0);
    check("sat_score_65530", sbus.o_score, 65530);
    sat_round(1'b0);
    check("sat_score_cap", sbus.o_score, 65535);
    sat_round(1'b0);
    check("sat_score_hold", sbus.o_score, 65535);
    check("sat_combo_hold", sbus.o_combo, 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
